// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } bcd_time_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [2:0] SEC_TENS_MAX = 3'd5;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the slow tick square wave into the iclk domain and emits a
// one-cycle pulse per rising edge.
module tick_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic reset,
  input  logic tick_in,
  output logic tick_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge iclk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/stopwatch_tick_counter.sv
// MM:SS.t BCD stopwatch advanced by synchronised 10 Hz tick edges.
// Define STOPWATCH_LAP_EN to add the lap/lap_hold frozen-display feature.
module stopwatch_tick_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       iclk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_hold,
`endif
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [2:0] MIN_TENS_MAX = 3'(MAX_MIN_TENS);

  logic      tick_edge;
  sw_state_t state_q, state_d;
  bcd_time_t cnt_q, cnt_d, cnt_inc, disp;
  logic      roll_q, roll_d;
  logic      inc, c1, c2, c3, c4, wrap;

  tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .iclk      (iclk),
    .reset     (reset),
    .tick_in   (tick_in),
    .tick_edge (tick_edge)
  );

  // Increment decision uses the current state, so a tick coinciding with
  // start_stop counts when leaving RUN but not when entering it.
  always_comb begin
    inc  = tick_edge && (state_q == RUN);
    c1   = (cnt_q.tenths == BCD_MAX);
    c2   = c1 && (cnt_q.sec_ones == BCD_MAX);
    c3   = c2 && (cnt_q.sec_tens == SEC_TENS_MAX);
    c4   = c3 && (cnt_q.min_ones == BCD_MAX);
    wrap = inc && c4 && (cnt_q.min_tens == MIN_TENS_MAX);
    cnt_inc = cnt_q;
    if (inc) begin
      cnt_inc.tenths = c1 ? 4'd0 : cnt_q.tenths + 4'd1;
      if (c1) cnt_inc.sec_ones = c2 ? 4'd0 : cnt_q.sec_ones + 4'd1;
      if (c2) cnt_inc.sec_tens = c3 ? 3'd0 : cnt_q.sec_tens + 3'd1;
      if (c3) cnt_inc.min_ones = c4 ? 4'd0 : cnt_q.min_ones + 4'd1;
      if (c4) cnt_inc.min_tens = (cnt_q.min_tens == MIN_TENS_MAX) ? 3'd0
                                                                  : cnt_q.min_tens + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    roll_d  = wrap;
    case (state_q)
      IDLE:    if (start_stop) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSE;
      PAUSE:   if (start_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      roll_d  = 1'b0;
    end
  end

  always_ff @(posedge iclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      roll_q  <= roll_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic      hold_q, hold_d;
  bcd_time_t snap_q, snap_d;

  // Snapshot is taken only when hold turns on; leaving RUN beats a lap pulse.
  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (state_q == RUN && lap) begin
      hold_d = ~hold_q;
      if (!hold_q) snap_d = cnt_q;
    end
    if ((state_q == RUN && start_stop) || clear) hold_d = 1'b0;
  end

  always_ff @(posedge iclk) begin
    if (reset) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign disp     = hold_q ? snap_q : cnt_q;
  assign lap_hold = hold_q;
`else
  assign disp = cnt_q;
`endif

  assign tenths   = disp.tenths;
  assign sec_ones = disp.sec_ones;
  assign sec_tens = disp.sec_tens;
  assign min_ones = disp.min_ones;
  assign min_tens = disp.min_tens;
  assign running  = (state_q == RUN);
  assign rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Directed bench for stopwatch_tick_counter; MAX_MIN_TENS=1 keeps the full
// wrap (19:59.9 -> 00:00.0) reachable in a short run.
module tb_stopwatch_tick_counter;

  localparam int MMT = 1;

  logic       iclk = 1'b0;
  logic       reset, tick_in, start_stop, clear;
  logic [3:0] tenths, sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;
  logic       running, rollover;
`ifdef STOPWATCH_LAP_EN
  logic       lap, lap_hold;
`endif

  int nvec = 0;
  int nerr = 0;
  int roll_seen = 0;

  stopwatch_tick_counter #(.SYNC_STAGES(2), .MAX_MIN_TENS(MMT)) dut (
    .iclk       (iclk),
    .reset      (reset),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
    .lap_hold   (lap_hold),
`endif
    .tenths     (tenths),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .rollover   (rollover)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    bit ss;
    bit clr;
    int ticks;
    int mt, mo, st, so, t;
    bit run;
  } vec_t;

  task automatic step();
    @(posedge iclk);
    #1;
    if (rollover === 1'b1) roll_seen++;
  endtask

  task automatic tick(input int n, input int hi, input int lo);
    repeat (n) begin
      tick_in = 1'b1;
      repeat (hi) step();
      tick_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  // Tick edge reaches the counter on the third edge; control lands on that edge.
  task automatic tick_ctl(input bit ss, input bit clr);
    tick_in = 1'b1;
    step();
    step();
    start_stop = ss;
    clear      = clr;
    step();
    start_stop = 1'b0;
    clear      = 1'b0;
    tick_in    = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_ctl(input bit ss, input bit clr);
    start_stop = ss;
    clear      = clr;
    step();
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic chk(input string nm, input int mt, input int mo, input int st,
                     input int so, input int t, input bit run);
    logic [18:0] got, exp;
    got = {min_tens, min_ones, sec_tens, sec_ones, tenths, running};
    exp = {3'(mt), 4'(mo), 3'(st), 4'(so), 4'(t), run};
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d%0d:%0d%0d.%0d running=%0d, expected %0d%0d:%0d%0d.%0d running=%0d",
               nm, min_tens, min_ones, sec_tens, sec_ones, tenths, running,
               mt, mo, st, so, t, run);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time bound");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    vt[0] = '{1, 0,  0, 0, 0, 0, 0, 0, 1};
    vt[1] = '{0, 0,  3, 0, 0, 0, 0, 3, 1};
    vt[2] = '{1, 0,  5, 0, 0, 0, 0, 3, 0};
    vt[3] = '{1, 0,  2, 0, 0, 0, 0, 5, 1};
    vt[4] = '{0, 0, 37, 0, 0, 0, 4, 2, 1};
    vt[5] = '{1, 1,  0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{0, 0,  4, 0, 0, 0, 0, 0, 0};
    vt[7] = '{1, 0, 10, 0, 0, 0, 1, 0, 1};
    vt[8] = '{0, 0, 99, 0, 0, 1, 0, 9, 1};
    vt[9] = '{0, 1,  0, 0, 0, 0, 0, 0, 0};

    reset = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    repeat (3) step();
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    chk_int("reset_rollover", int'(rollover), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vt[i].ss || vt[i].clr) pulse_ctl(vt[i].ss, vt[i].clr);
      tick(vt[i].ticks, 2, 2);
      chk($sformatf("vec%0d", i), vt[i].mt, vt[i].mo, vt[i].st, vt[i].so, vt[i].t, vt[i].run);
    end

    // 10 Hz-like square wave, 5 cycles high / 5 low
    pulse_ctl(1, 0);
    tick(10, 5, 5);
    chk("slow_10_ticks", 0, 0, 0, 1, 0, 1);

    tick_in = 1'b1;
    repeat (40) step();
    tick_in = 1'b0;
    repeat (3) step();
    chk("held_high_one_inc", 0, 0, 0, 1, 1, 1);

    tick_ctl(1, 0);
    chk("run_ss_tick_counts", 0, 0, 0, 1, 2, 0);
    tick_ctl(1, 0);
    chk("pause_ss_tick_skips", 0, 0, 0, 1, 2, 1);
    tick(1, 2, 2);
    chk("resume_counts", 0, 0, 0, 1, 3, 1);
    tick_ctl(0, 1);
    chk("clear_with_tick", 0, 0, 0, 0, 0, 0);

    pulse_ctl(1, 0);
    tick(77, 2, 2);
    chk("at_07_7", 0, 0, 0, 7, 7, 1);
    roll_seen = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_count", 0, 0, 0, 0, 0, 0);
    chk_int("reset_no_rollover", roll_seen, 0);
    tick(2, 2, 2);
    chk("idle_after_reset", 0, 0, 0, 0, 0, 0);

    pulse_ctl(1, 0);
    roll_seen = 0;
    tick(599, 2, 2);
    chk("at_00_59_9", 0, 0, 5, 9, 9, 1);
    tick(1, 2, 2);
    chk("carry_01_00_0", 0, 1, 0, 0, 0, 1);
    tick(5399, 2, 2);
    chk("at_09_59_9", 0, 9, 5, 9, 9, 1);
    tick(1, 2, 2);
    chk("carry_10_00_0", 1, 0, 0, 0, 0, 1);
    tick(5999, 2, 2);
    chk("at_max", 1, 9, 5, 9, 9, 1);
    chk_int("no_rollover_before_max", roll_seen, 0);
    tick(1, 2, 2);
    chk("wrap_to_zero", 0, 0, 0, 0, 0, 1);
    chk_int("rollover_one_cycle", roll_seen, 1);
    tick(1, 2, 2);
    chk("count_after_wrap", 0, 0, 0, 0, 1, 1);
    chk_int("rollover_not_repeated", roll_seen, 1);

`ifdef STOPWATCH_LAP_EN
    pulse_ctl(0, 1);
    pulse_ctl(1, 0);
    tick(20, 2, 2);
    lap = 1'b1; step(); lap = 1'b0;
    tick(10, 2, 2);
    chk("lap_frozen", 0, 0, 0, 2, 0, 1);
    chk_int("lap_hold_on", int'(lap_hold), 1);
    lap = 1'b1; step(); lap = 1'b0;
    chk("lap_release_live", 0, 0, 0, 3, 0, 1);
    chk_int("lap_hold_off", int'(lap_hold), 0);
    lap = 1'b1; step(); lap = 1'b0;
    tick(5, 2, 2);
    chk("lap_frozen2", 0, 0, 0, 3, 0, 1);
    pulse_ctl(1, 0);
    chk("pause_shows_live", 0, 0, 0, 3, 5, 0);
    chk_int("pause_clears_hold", int'(lap_hold), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
